// File: rtl/packed_sched_pkg.sv
// Shared definitions for the packed field sequencer.
//   sched_state_t : controller state encoding
//   FILL_DEFAULT  : shadow pattern after reset / clearing commit
//   CNT_W         : width of the merged-write counter
package packed_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIRTY   = 2'd1,
    ST_PRESENT = 2'd2
  } sched_state_t;

  localparam logic [15:0] FILL_DEFAULT = 16'hFC00;
  localparam int          CNT_W        = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with an internal last-grant pointer.
//   clk, rst_n : clock, async active-low reset
//   req        : per-requester request
//   enable     : grants are only issued while high
//   gnt        : one-hot grant (combinational)
// The search starts one past the last granted index; the pointer resets to
// N-1 so requester 0 has first priority.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         enable,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] gnt_idx;
  logic          found;
  int            idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    if (enable) begin
      for (int k = 1; k <= N; k++) begin
        idx = (int'(ptr_q) + k) % N;
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          gnt_idx  = PW'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PW'(N - 1);
    end else if (found) begin
      ptr_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/packed_field_sched.sv
// Packed field sequencer: merges one granted slice write per cycle into a
// shadow word and presents it downstream on commit.
//   clk, rst_n     : clock, async active-low reset
//   req_*          : per-requester slice writes (valid, start, length, data)
//   req_gnt        : one-hot grant; the write lands in the grant cycle
//   commit_valid/ready : request to present the shadow word
//   out_valid/ready, out_word, out_nwrites : presented word and write count
//
// state      | meaning
// -----------+--------------------------------------------
// ST_IDLE    | no slice writes since the last commit
// ST_DIRTY   | at least one slice write since the last commit
// ST_PRESENT | word presented, waiting for out_ready
module packed_field_sched
  import packed_sched_pkg::*;
#(
  parameter int                NUM_REQ         = 3,
  parameter int                WORD_W          = 16,
  parameter int                LO_W            = 4,
  parameter int                LEN_W           = 5,
  parameter logic [WORD_W-1:0] FILL_VALUE      = FILL_DEFAULT,
  parameter bit                CLEAR_ON_COMMIT = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*LO_W-1:0]   req_lo_flat,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len_flat,
  input  logic [NUM_REQ*WORD_W-1:0] req_data_flat,
  output logic [NUM_REQ-1:0]        req_gnt,
  input  logic                      commit_valid,
  output logic                      commit_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_W-1:0]         out_word,
  output logic [CNT_W-1:0]          out_nwrites
);

  // Bits landing past the top of the word are dropped; lengths above
  // WORD_W are implicitly clamped by the loop bound.
  function automatic logic [WORD_W-1:0] merge_slice(
    input logic [WORD_W-1:0] base,
    input logic [LO_W-1:0]   lo,
    input logic [LEN_W-1:0]  len,
    input logic [WORD_W-1:0] data
  );
    logic [WORD_W-1:0] res;
    res = base;
    for (int b = 0; b < WORD_W; b++) begin
      if (b < int'(len) && (int'(lo) + b) < WORD_W) begin
        res[int'(lo) + b] = data[b];
      end
    end
    return res;
  endfunction

  sched_state_t      state_q, state_d;
  logic [WORD_W-1:0] shadow_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] word_q;
  logic [CNT_W-1:0]  nwrites_q;

  logic              commit_acc;
  logic              arb_en;
  logic              wr_en;
  logic              out_hs;
  logic [LO_W-1:0]   sel_lo;
  logic [LEN_W-1:0]  sel_len;
  logic [WORD_W-1:0] sel_data;

  assign commit_ready = (state_q != ST_PRESENT);
  assign commit_acc   = commit_valid && commit_ready;
  // Commit wins over a write in the same cycle.
  assign arb_en       = commit_ready && !commit_valid;
  assign wr_en        = |req_gnt;
  assign out_valid    = (state_q == ST_PRESENT);
  assign out_hs       = out_valid && out_ready;
  assign out_word     = word_q;
  assign out_nwrites  = nwrites_q;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .enable (arb_en),
    .gnt    (req_gnt)
  );

  always_comb begin
    sel_lo   = '0;
    sel_len  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_gnt[i]) begin
        sel_lo   = req_lo_flat[i*LO_W +: LO_W];
        sel_len  = req_len_flat[i*LEN_W +: LEN_W];
        sel_data = req_data_flat[i*WORD_W +: WORD_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (commit_acc)  state_d = ST_PRESENT;
        else if (wr_en)  state_d = ST_DIRTY;
      end
      ST_DIRTY: begin
        if (commit_acc)  state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (out_ready)   state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shadow_q  <= FILL_VALUE;
      cnt_q     <= '0;
      word_q    <= '0;
      nwrites_q <= '0;
    end else begin
      state_q <= state_d;
      if (commit_acc) begin
        word_q    <= shadow_q;
        nwrites_q <= cnt_q;
        cnt_q     <= '0;
      end else if (wr_en) begin
        shadow_q <= merge_slice(shadow_q, sel_lo, sel_len, sel_data);
        if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
      end
      if (out_hs && CLEAR_ON_COMMIT) begin
        shadow_q <= FILL_VALUE;
      end
    end
  end

endmodule

// File: doc/packed_field_sched.md
Name: packed_field_sched

Overview:
Owns a single WORD_W-bit packed register that is built from overlapping slice writes on top of a constant fill pattern. It arbitrates round-robin between NUM_REQ field writers, merges one slice per cycle into a shadow word, and presents the assembled word downstream on commit with a valid/ready handshake. It is the sequencer in front of packed-vector datapaths where later slice writes override earlier ones.

Parameters:
NUM_REQ, 3, number of field-write requesters
WORD_W, 16, packed word width
LO_W, 4, width of the slice start index (clog2 WORD_W)
LEN_W, 5, width of the slice length (0..WORD_W)
FILL_VALUE, 16'hFC00, shadow value after reset and after a clearing commit
CLEAR_ON_COMMIT, 1, 1: shadow returns to FILL_VALUE after the output handshake; 0: shadow is retained

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester write request
req_lo_flat  input  NUM_REQ*LO_W  slice start bit; requester i occupies bits [i*LO_W +: LO_W]
req_len_flat  input  NUM_REQ*LEN_W  slice length
req_data_flat  input  NUM_REQ*WORD_W  slice data, right-aligned
req_gnt  output  NUM_REQ  one-hot grant (combinational); the write occurs in the grant cycle
commit_valid  input  1  request to present the shadow word
commit_ready  output  1  commit accepted when commit_valid && commit_ready
out_valid  output  1  presented word valid
out_ready  input  1  downstream accept
out_word  output  WORD_W  presented word
out_nwrites  output  8  number of slice writes merged since the previous commit, saturating at 255

Behaviour:
- Reset values (asynchronous, rst_n=0): shadow=FILL_VALUE; out_valid=0; out_word=0; out_nwrites=0; write counter=0; state=IDLE; RR pointer=NUM_REQ-1, so requester 0 wins first.
- FSM states:
  - IDLE: no writes since the last commit.
  - DIRTY: at least one write since the last commit.
  - PRESENT: out_valid=1, waiting for out_ready.
- Transitions:
  - IDLE→DIRTY on a granted write.
  - IDLE/DIRTY→PRESENT on commit accept.
  - PRESENT→IDLE on out_valid && out_ready.
- commit_ready is 1 in IDLE and DIRTY, 0 in PRESENT.
- Grants:
  - At most one grant per cycle, only in IDLE or DIRTY.
  - No grant in a cycle where a commit is accepted; commit has priority.
  - No grant in PRESENT; requesters hold their requests.
- Round-robin search starts at pointer+1 mod NUM_REQ. The pointer updates to the granted index.
- Slice merge, with L = min(len, WORD_W): for b in 0..L-1, if lo+b < WORD_W then shadow[lo+b] = data[b].
  - Bits past WORD_W are dropped; there is no wrap.
  - len=0 is still granted and counted, but leaves the shadow unchanged.
  - len > WORD_W is clamped to WORD_W.
- Writes are applied in grant order, so later writes override overlapping bits.
- Commit accept (1-cycle latency): the next cycle shows out_word=shadow, out_nwrites=counter, out_valid=1. The counter is cleared in the same edge.
- Commit in IDLE is legal and presents the current shadow with out_nwrites=0.
- out_word and out_nwrites are held stable while out_valid && !out_ready.
- On the handshake: out_valid→0, out_word keeps its value, and the shadow becomes FILL_VALUE if CLEAR_ON_COMMIT=1.
- The write counter saturates at 255.
- Reset mid-operation: all state returns to reset values immediately; any in-flight output is discarded.

Decomposition:
- Shared package packed_sched_pkg: state enum (IDLE, DIRTY, PRESENT), default FILL_VALUE constant, counter width constant.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req, enable, pointer state.
  - Output: one-hot gnt.
  - Pointer flops live inside rr_arbiter, clocked on clk/rst_n.
- Slice-merge function: kept in packed_field_sched.

Test Plan:
- Reset, then req0 lo=0 len=10 data=0x155, then req1 lo=0 len=1 data=0, then commit → out_word=0xFD54, out_nwrites=2, out_valid one cycle after accept.
- Fresh shadow 0xFC00; req2 lo=14 len=4 data=0x0; commit → out_word=0x3C00 (upper two bits dropped, no wrap), out_nwrites=1.
- All three requesters valid simultaneously from reset:
  - Requests: req0 lo=0 len=8 data=0xAA; req1 lo=4 len=8 data=0x00; req2 lo=0 len=2 data=0x3.
  - Required: grants 0,1,2 on consecutive cycles; commit → out_word=0xF00B.
- commit_valid and req_valid[0] asserted in the same cycle in DIRTY with out_ready=0 for 3 cycles:
  - Commit is accepted; req_gnt=0 and commit_ready=0 during PRESENT.
  - out_word is stable across the stall.
  - Grant to req0 occurs the cycle after the handshake, with shadow starting from 0xFC00.
- Commit with no writes → out_word=0xFC00, out_nwrites=0; len=0 write → counted, word unchanged.
- Assert rst_n=0 while in PRESENT → out_valid=0 asynchronously; after release, commit → out_word=0xFC00.
